// File: rtl/matrix_operand_store_if.sv
// Load stream and A/B read ports of the matrix operand store.
// slave = store side, master = host/DMA plus MAC unit side.
interface matrix_operand_store_if #(
  parameter int M                      = 2,
  parameter int K                      = 2,
  parameter int N                      = 2,
  parameter int DATA_WIDTH_INIT_MATRIX = 32
) ();
  localparam int DW  = DATA_WIDTH_INIT_MATRIX;
  localparam int MW  = $clog2(M);
  localparam int KW  = $clog2(K);
  localparam int NW  = $clog2(N);

  logic          load_start;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          load_done;
  logic          operands_valid;

  logic          matrix_a_re;
  logic [MW-1:0] row_addr_a;
  logic [KW-1:0] col_addr_a;
  logic          matrix_b_re;
  logic [KW-1:0] row_addr_b;
  logic [NW-1:0] col_addr_b;
  logic [DW-1:0] data_in_a;
  logic [DW-1:0] data_in_b;
  logic          data_a_valid;
  logic          data_b_valid;
  logic          rd_err;

  modport slave (
    input  load_start, load_valid, load_data,
    input  matrix_a_re, row_addr_a, col_addr_a,
    input  matrix_b_re, row_addr_b, col_addr_b,
    output load_ready, load_done, operands_valid,
    output data_in_a, data_in_b, data_a_valid, data_b_valid, rd_err
  );

  modport master (
    output load_start, load_valid, load_data,
    output matrix_a_re, row_addr_a, col_addr_a,
    output matrix_b_re, row_addr_b, col_addr_b,
    input  load_ready, load_done, operands_valid,
    input  data_in_a, data_in_b, data_a_valid, data_b_valid, rd_err
  );
endinterface

// File: rtl/matrix_operand_store.sv
// Operand memory for the matrix MAC: row-major A then B load stream,
// two independent read ports with one-cycle registered latency.
module matrix_operand_store #(
  parameter int M                      = 2,
  parameter int K                      = 2,
  parameter int N                      = 2,
  parameter int DATA_WIDTH_INIT_MATRIX = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  matrix_operand_store_if.slave  bus
);
  localparam int DW      = DATA_WIDTH_INIT_MATRIX;
  localparam int A_WORDS = M * K;
  localparam int B_WORDS = K * N;
  localparam int AAW     = $clog2(A_WORDS);
  localparam int BAW     = $clog2(B_WORDS);
  localparam int DMAX    = (M > K) ? ((M > N) ? M : N) : ((K > N) ? K : N);
  localparam int CW      = $clog2(DMAX);

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, READY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wr_row, wr_col, wr_row_nxt, wr_col_nxt;
  logic [DW-1:0] mem_a [A_WORDS];
  logic [DW-1:0] mem_b [B_WORDS];

  logic           start_load, wr_a, wr_b, col_last, row_last;
  int             col_max, row_max;
  logic [AAW-1:0] wa_addr, ra_addr;
  logic [BAW-1:0] wb_addr, rb_addr;
  logic           rd_ok_a, rd_ok_b, rd_bad;

  // Counter limits follow whichever matrix is being written.
  always_comb begin
    col_max = (state == LOAD_B) ? N - 1 : K - 1;
    row_max = (state == LOAD_B) ? K - 1 : M - 1;
  end

  assign col_last = (int'(wr_col) == col_max);
  assign row_last = (int'(wr_row) == row_max);

  always_comb begin
    state_nxt      = state;
    wr_row_nxt     = wr_row;
    wr_col_nxt     = wr_col;
    start_load     = 1'b0;
    wr_a           = 1'b0;
    wr_b           = 1'b0;
    bus.load_ready = 1'b0;
    bus.load_done  = 1'b0;
    case (state)
      IDLE, READY: begin
        if (bus.load_start) begin
          state_nxt  = LOAD_A;
          start_load = 1'b1;
          wr_row_nxt = '0;
          wr_col_nxt = '0;
        end
      end
      LOAD_A, LOAD_B: begin
        bus.load_ready = 1'b1;
        if (bus.load_valid) begin
          wr_a = (state == LOAD_A);
          wr_b = (state == LOAD_B);
          if (col_last) begin
            wr_col_nxt = '0;
            wr_row_nxt = wr_row + 1'b1;
          end else begin
            wr_col_nxt = wr_col + 1'b1;
          end
          if (col_last && row_last) begin
            wr_row_nxt = '0;
            wr_col_nxt = '0;
            if (state == LOAD_A) begin
              state_nxt = LOAD_B;
            end else begin
              state_nxt     = READY;
              bus.load_done = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wa_addr = AAW'(int'(wr_row) * K + int'(wr_col));
  assign wb_addr = BAW'(int'(wr_row) * N + int'(wr_col));
  assign ra_addr = AAW'(int'(bus.row_addr_a) * K + int'(bus.col_addr_a));
  assign rb_addr = BAW'(int'(bus.row_addr_b) * N + int'(bus.col_addr_b));

  // Reads are served only once both matrices are complete and in range.
  assign rd_ok_a = bus.operands_valid && (int'(bus.row_addr_a) < M) && (int'(bus.col_addr_a) < K);
  assign rd_ok_b = bus.operands_valid && (int'(bus.row_addr_b) < K) && (int'(bus.col_addr_b) < N);
  assign rd_bad  = (bus.matrix_a_re && !rd_ok_a) || (bus.matrix_b_re && !rd_ok_b);

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      wr_row             <= '0;
      wr_col             <= '0;
      bus.operands_valid <= 1'b0;
      bus.data_in_a      <= '0;
      bus.data_in_b      <= '0;
      bus.data_a_valid   <= 1'b0;
      bus.data_b_valid   <= 1'b0;
      bus.rd_err         <= 1'b0;
    end else begin
      state              <= state_nxt;
      wr_row             <= wr_row_nxt;
      wr_col             <= wr_col_nxt;
      bus.operands_valid <= start_load ? 1'b0 : (bus.load_done | bus.operands_valid);
      bus.data_a_valid   <= bus.matrix_a_re && rd_ok_a;
      bus.data_b_valid   <= bus.matrix_b_re && rd_ok_b;
      bus.data_in_a      <= (bus.matrix_a_re && rd_ok_a) ? mem_a[ra_addr] : '0;
      bus.data_in_b      <= (bus.matrix_b_re && rd_ok_b) ? mem_b[rb_addr] : '0;
      // A bad read in the same cycle as a restart still flags.
      bus.rd_err         <= (bus.rd_err & ~start_load) | rd_bad;
    end
  end

  // Storage is not reset; operands_valid gates every read.
  always_ff @(posedge clk) begin
    if (wr_a && !reset) mem_a[wa_addr] <= bus.load_data;
    if (wr_b && !reset) mem_b[wb_addr] <= bus.load_data;
  end
endmodule

// File: tb/tb_matrix_operand_store.sv
// Bench for matrix_operand_store: flat-index load model plus per-cycle compare,
// directed test-plan cases and a randomized phase.
module tb_matrix_operand_store;
  localparam int M   = 2;
  localparam int K   = 2;
  localparam int N   = 2;
  localparam int DW  = 32;
  localparam int NA  = M * K;
  localparam int NB  = K * N;
  localparam int TOT = NA + NB;
  localparam int MW  = $clog2(M);
  localparam int KW  = $clog2(K);
  localparam int NW  = $clog2(N);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  matrix_operand_store_if #(.M(M), .K(K), .N(N), .DATA_WIDTH_INIT_MATRIX(DW)) bus ();

  matrix_operand_store #(.M(M), .K(K), .N(N), .DATA_WIDTH_INIT_MATRIX(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the load is one flat stream of TOT words.
  logic [DW-1:0] ma [NA];
  logic [DW-1:0] mb [NB];
  bit            loading, loaded, err, started, ok_a, ok_b;
  int            widx;
  logic [DW-1:0] e_da, e_db;
  bit            e_va, e_vb;

  always @(posedge clk) begin
    if (reset) begin
      loading = 0; loaded = 0; err = 0; widx = 0;
      e_da = '0; e_db = '0; e_va = 0; e_vb = 0;
      started = 1;
    end else if (started) begin
      ok_a = loaded && (int'(bus.row_addr_a) < M) && (int'(bus.col_addr_a) < K);
      ok_b = loaded && (int'(bus.row_addr_b) < K) && (int'(bus.col_addr_b) < N);
      if (!loading && bus.load_start) err = 0;
      e_va = bus.matrix_a_re && ok_a;
      e_vb = bus.matrix_b_re && ok_b;
      e_da = e_va ? ma[int'(bus.row_addr_a) * K + int'(bus.col_addr_a)] : '0;
      e_db = e_vb ? mb[int'(bus.row_addr_b) * N + int'(bus.col_addr_b)] : '0;
      if ((bus.matrix_a_re && !ok_a) || (bus.matrix_b_re && !ok_b)) err = 1;
      if (!loading && bus.load_start) begin
        loading = 1; loaded = 0; widx = 0;
      end else if (loading && bus.load_valid) begin
        if (widx < NA) ma[widx] = bus.load_data;
        else           mb[widx - NA] = bus.load_data;
        widx++;
        if (widx == TOT) begin
          loading = 0; loaded = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("load_ready", {31'b0, bus.load_ready}, {31'b0, loading});
      chk("load_done", {31'b0, bus.load_done},
          {31'b0, (loading && bus.load_valid && widx == TOT - 1)});
      chk("operands_valid", {31'b0, bus.operands_valid}, {31'b0, loaded});
      chk("data_in_a", bus.data_in_a, e_da);
      chk("data_in_b", bus.data_in_b, e_db);
      chk("data_a_valid", {31'b0, bus.data_a_valid}, {31'b0, e_va});
      chk("data_b_valid", {31'b0, bus.data_b_valid}, {31'b0, e_vb});
      chk("rd_err", {31'b0, bus.rd_err}, {31'b0, err});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0;
    bus.matrix_a_re = 0; bus.row_addr_a = '0; bus.col_addr_a = '0;
    bus.matrix_b_re = 0; bus.row_addr_b = '0; bus.col_addr_b = '0;
  endtask

  task automatic set_rd(input bit ea, input int ra, input int ca,
                        input bit eb, input int rb, input int cb);
    bus.matrix_a_re = ea; bus.row_addr_a = MW'(ra); bus.col_addr_a = KW'(ca);
    bus.matrix_b_re = eb; bus.row_addr_b = KW'(rb); bus.col_addr_b = NW'(cb);
  endtask

  task automatic rd(input bit ea, input int ra, input int ca,
                    input bit eb, input int rb, input int cb);
    set_rd(ea, ra, ca, eb, rb, cb);
    cyc();
    bus.matrix_a_re = 0; bus.matrix_b_re = 0;
  endtask

  task automatic load_seq(input int base, input bit gap, input int nwords);
    bus.load_start = 1;
    cyc();
    bus.load_start = 0;
    for (int w = 0; w < nwords; w++) begin
      if (gap) begin
        bus.load_valid = 0;
        cyc();
      end
      bus.load_valid = 1;
      bus.load_data  = DW'(base + w);
      if (w == TOT - 1) begin
        @(negedge clk);
        chk("load_done_last", {31'b0, bus.load_done}, 32'd1);
      end
      cyc();
    end
    bus.load_valid = 0;
  endtask

  initial begin
    idle_in();
    reset = 1;
    cyc();
    @(negedge clk);
    chk("rst_operands_valid", {31'b0, bus.operands_valid}, 32'd0);
    chk("rst_load_ready", {31'b0, bus.load_ready}, 32'd0);
    chk("rst_rd_err", {31'b0, bus.rd_err}, 32'd0);
    chk("rst_data_a_valid", {31'b0, bus.data_a_valid}, 32'd0);
    cyc();
    reset = 0;

    // A=[1,2;3,4], B=[5,6;7,8]
    load_seq(1, 0, TOT);
    @(negedge clk);
    chk("ov_after_load", {31'b0, bus.operands_valid}, 32'd1);
    cyc();
    rd(1, 1, 0, 1, 0, 1);
    @(negedge clk);
    chk("a10", bus.data_in_a, 32'd3);
    chk("b01", bus.data_in_b, 32'd6);
    chk("a10_valid", {31'b0, bus.data_a_valid}, 32'd1);
    chk("b01_valid", {31'b0, bus.data_b_valid}, 32'd1);
    cyc();
    @(negedge clk);
    chk("a_valid_drop", {31'b0, bus.data_a_valid}, 32'd0);
    chk("b_valid_drop", {31'b0, bus.data_b_valid}, 32'd0);
    cyc();

    // MAC order, one pair per cycle, no gaps
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < K; k++) begin
          set_rd(1, i, k, 1, k, j);
          cyc();
        end
    bus.matrix_a_re = 0; bus.matrix_b_re = 0;
    @(negedge clk);
    chk("mac_last_a11", bus.data_in_a, 32'd4);
    chk("mac_last_b11", bus.data_in_b, 32'd8);
    cyc();

    // Read in IDLE flags an error; load_start clears it
    reset = 1; cyc(); reset = 0;
    rd(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("idle_rd_data", bus.data_in_a, 32'd0);
    chk("idle_rd_valid", {31'b0, bus.data_a_valid}, 32'd0);
    chk("idle_rd_err", {31'b0, bus.rd_err}, 32'd1);
    bus.load_start = 1;
    cyc();
    bus.load_start = 0;
    @(negedge clk);
    chk("rd_err_cleared", {31'b0, bus.rd_err}, 32'd0);
    cyc();

    // Already in LOAD_A: this start pulse is ignored, stream proceeds with gaps
    load_seq(21, 1, TOT);
    rd(1, 0, 1, 1, 1, 0);
    @(negedge clk);
    chk("gap_a01", bus.data_in_a, 32'd22);
    chk("gap_b10", bus.data_in_b, 32'd27);
    cyc();

    // Abort after 5 words, then full reload
    load_seq(100, 0, 5);
    reset = 1; cyc(); reset = 0;
    @(negedge clk);
    chk("abort_ov", {31'b0, bus.operands_valid}, 32'd0);
    cyc();
    load_seq(11, 0, TOT);
    rd(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("reload_a00", bus.data_in_a, 32'd11);
    cyc();

    for (int c = 0; c < 600; c++) begin
      reset          = ($urandom_range(0, 149) == 0);
      bus.load_start = ($urandom_range(0, 24) == 0);
      bus.load_valid = $urandom_range(0, 3) != 0;
      bus.load_data  = $urandom;
      if (bus.load_start) set_rd(0, 0, 0, 0, 0, 0);
      else set_rd($urandom_range(0, 1), $urandom_range(0, M - 1), $urandom_range(0, K - 1),
                  $urandom_range(0, 1), $urandom_range(0, K - 1), $urandom_range(0, N - 1));
      cyc();
    end
    idle_in();
    reset = 0;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
